// File: rtl/hex_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
// Shared constants, types and the hex-to-7-segment decode table for the
// hex_display_scanner block.
//   NUM_DIGITS      number of multiplexed digits
//   SEG_BLANK       active-low segment pattern with every segment off
//   SEG7_TABLE      16-entry decode table, active-high, bit0 = a .. bit6 = g
//   disp_out_t      bundle of the registered pin-facing outputs
//   nibble_to_seg7  table lookup helper
// -----------------------------------------------------------------------------
package hex_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index = nibble value; entries are gfedcba, active-high.
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] dig_en_n;
  } disp_out_t;

  // Everything dark: segments off, decimal point off, no digit selected.
  localparam disp_out_t DISP_IDLE = '{seg_n: SEG_BLANK, dp_n: 1'b1, dig_en_n: 4'hF};

  function automatic logic [6:0] nibble_to_seg7(input logic [3:0] nibble);
    return SEG7_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// -----------------------------------------------------------------------------
// hex_display_scanner_if
// Groups the PIO-side inputs and the board-pin outputs of the display scanner.
//   hex_value  [15:0]  four digit nibbles, [3:0] = rightmost digit
//   dp_mask    [3:0]   decimal point request per digit (1 = lit)
//   blank_lz           leading-zero suppression enable
//   blink_en           blink the whole display
//   seg_n      [6:0]   segments, active-low, bit0 = a .. bit6 = g
//   dp_n               decimal point, active-low
//   dig_en_n   [3:0]   digit enables, active-low, one-hot-or-none
//   frame_done         one-cycle pulse at the end of each 4-digit frame
// master = the side that supplies the digit data (PIO / testbench);
// slave  = the scanner itself.
// -----------------------------------------------------------------------------
interface hex_display_scanner_if;

  logic [15:0] hex_value;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  dig_en_n;
  logic        frame_done;

  modport master (
    output hex_value, dp_mask, blank_lz, blink_en,
    input  seg_n, dp_n, dig_en_n, frame_done
  );

  modport slave (
    input  hex_value, dp_mask, blank_lz, blink_en,
    output seg_n, dp_n, dig_en_n, frame_done
  );

endinterface

// File: rtl/hex_display_scanner_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational nibble to 7-segment decoder driven from the package
// table.
//   nibble  [3:0]  hex digit value
//   seg     [6:0]  segments, active-high, bit0 = a .. bit6 = g
// -----------------------------------------------------------------------------
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = nibble_to_seg7(nibble);

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
// Drives a 4-digit time-multiplexed 7-segment display from a 16-bit hex value.
// The digit data is captured once per frame into a shadow register so a value
// written mid-frame never produces a torn display. Each digit slot starts with
// a short all-off window to stop the previous digit ghosting into the next.
// Also provides leading-zero suppression and whole-display blink.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    slave side of hex_display_scanner_if (data in, pins out)
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (>= 4)
//   BLANK_CYCLES  all-off cycles at the start of each slot (< SCAN_DIV)
//   BLINK_FRAMES  frames on, then frames off, while blinking (>= 1)
// -----------------------------------------------------------------------------
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_display_scanner_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END     = PW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST    = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] prescale;
  digit_idx_t    idx;
  logic [15:0]   shadow;
  logic [3:0]    dp_shadow;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          tick;
  logic          frame_end;
  logic          frame_start;
  logic          display_off;
  logic [3:0]    suppress;
  logic          active;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_seg;

  disp_out_t     out_next;
  disp_out_t     out_q;
  logic          frame_done_q;

  assign tick        = (prescale == PRESCALE_LAST);
  assign frame_end   = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));
  assign frame_start = (idx == '0) && (prescale == '0);

  // ---------------------------------------------------------------------------
  // Slot timing: prescaler and digit index.
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      idx      <= '0;
    end else begin
      if (tick) begin
        prescale <= '0;
        idx      <= idx + digit_idx_t'(1);  // 2-bit index wraps 3 -> 0
      end else begin
        prescale <= prescale + PW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-synchronous shadow capture. Inputs are only looked at on the very
  // first cycle of a frame, so a whole frame always shows one coherent value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow    <= '0;
      dp_shadow <= '0;
    end else if (frame_start) begin
      shadow    <= bus.hex_value;
      dp_shadow <= bus.dp_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink: counts frames continuously so enabling blink joins the running
  // on/off cadence instead of restarting it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BW'(1);
      end
    end
  end

  assign display_off = bus.blink_en && blink_phase;

  // ---------------------------------------------------------------------------
  // Leading-zero suppression on the captured value. A digit is blanked only
  // when it and every digit to its left are zero; the rightmost digit always
  // shows so a zero value still displays "0".
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    suppress = '0;
    if (bus.blank_lz) begin
      suppress[3] = (shadow[15:12] == 4'h0);
      suppress[2] = (shadow[15:8]  == 8'h00);
      suppress[1] = (shadow[15:4]  == 12'h000);
    end
  end

  assign active     = (prescale >= BLANK_END) && !display_off && !suppress[idx];
  assign cur_nibble = shadow[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    out_next = DISP_IDLE;
    if (active) begin
      out_next.seg_n    = ~cur_seg;
      out_next.dp_n     = ~dp_shadow[idx];
      out_next.dig_en_n = ~(4'b0001 << idx);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered pin drivers: glitch-free outputs, dark while in reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= DISP_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      out_q        <= out_next;
      frame_done_q <= frame_end;
    end
  end

  assign bus.seg_n      = out_q.seg_n;
  assign bus.dp_n       = out_q.dp_n;
  assign bus.dig_en_n   = out_q.dig_en_n;
  assign bus.frame_done = frame_done_q;

endmodule
